fringe_sequencer: RTL and testbench

//  Frame sequencer for the structured-light projector, directly upstream of the DDS fringe generator.

---
 rtl/fringe_sequencer.sv | 207 ++++++++++++++++++++
 tb/tb_fringe_sequencer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/fringe_sequencer.sv
// Structured-light frame sequencer: walks NUM_FREQ x NUM_STEP fringe patterns plus NUM_STEP DC
// frames in lock-step with HDMI vsync and the camera handshake, feeding DDS phase words.
module fringe_sequencer #(
  parameter int unsigned NUM_FREQ   = 60,
  parameter int unsigned STEP_LOG2  = 3,
  parameter int unsigned VS_PER_PAT = 2,
  parameter int unsigned TRIG_LEN   = 16
) (
  input  logic        clk_25,
  input  logic        reset_n,
  input  logic        sync_vs,
  input  logic        sync_in_1,
  input  logic        sync_in_2,
  output logic [31:0] phase_inc,
  output logic [31:0] phase_off,
  output logic [8:0]  frame_idx,
  output logic        cam_trig,
  output logic        seq_done,
  output logic        busy
);

  localparam int unsigned NumStep  = 1 << STEP_LOG2;
  localparam int unsigned NumPhase = NUM_FREQ * NumStep;
  localparam int unsigned NumIdx   = NumPhase + NumStep;
  localparam int unsigned CntW     = $clog2(VS_PER_PAT + 1);
  localparam int unsigned TrigW    = $clog2(TRIG_LEN + 1);

  localparam logic [8:0]       LastIdx  = 9'(NumIdx - 1);
  localparam logic [CntW-1:0]  VsLast   = CntW'(VS_PER_PAT - 1);
  localparam logic [TrigW-1:0] TrigLoad = TrigW'(TRIG_LEN);
  localparam logic [31:0]      Dividend = 32'h2000_0000;

  typedef enum logic [1:0] {StIdle, StArm, StRun, StHold} state_e;

  state_e            state_q, state_d;
  logic              vs_q, ena_meta_q, ena_q, rdy_meta_q, rdy_q;
  logic              vs_rise, vs_fall;
  logic [CntW-1:0]   vs_cnt_q, vs_cnt_d;
  logic [8:0]        frame_idx_q, frame_idx_d;
  logic              seq_done_q, seq_done_d;
  logic              trig_fire;
  logic [TrigW-1:0]  trig_cnt_q, trig_cnt_d;
  logic              cam_trig_q;

  logic              div_start;
  logic [5:0]        div_cnt_q;
  logic [31:0]       div_rem_q, div_quo_q, div_den_q, off_pend_q;
  logic              div_dc_q, busy_q;
  logic [31:0]       phase_inc_q, phase_off_q;
  logic [31:0]       k_val, off_val;
  logic              dc_val;
  logic [32:0]       rem_sh, rem_diff;

  assign vs_rise = sync_vs & ~vs_q;
  assign vs_fall = ~sync_vs & vs_q;

  always_ff @(posedge clk_25 or negedge reset_n) begin
    if (!reset_n) begin
      vs_q       <= 1'b0;
      ena_meta_q <= 1'b0;
      ena_q      <= 1'b0;
      rdy_meta_q <= 1'b0;
      rdy_q      <= 1'b0;
    end else begin
      vs_q       <= sync_vs;
      ena_meta_q <= sync_in_1;
      ena_q      <= ena_meta_q;
      rdy_meta_q <= sync_in_2;
      rdy_q      <= rdy_meta_q;
    end
  end

  // Losing ena has priority over everything, including a coincident vs_fall advance.
  always_comb begin
    state_d     = state_q;
    vs_cnt_d    = vs_cnt_q;
    frame_idx_d = frame_idx_q;
    seq_done_d  = 1'b0;
    trig_fire   = 1'b0;
    if (!ena_q) begin
      state_d     = StIdle;
      vs_cnt_d    = '0;
      frame_idx_d = '0;
    end else begin
      unique case (state_q)
        StIdle: state_d = StArm;
        StArm: begin
          if (vs_fall) begin
            state_d  = StRun;
            vs_cnt_d = '0;
          end
        end
        StRun: begin
          if (vs_rise && (vs_cnt_q == '0) && rdy_q) trig_fire = 1'b1;
          if (vs_fall) begin
            if (!rdy_q) begin
              state_d = StHold;
            end else if (vs_cnt_q == VsLast) begin
              vs_cnt_d = '0;
              if (frame_idx_q == LastIdx) begin
                frame_idx_d = '0;
                seq_done_d  = 1'b1;
              end else begin
                frame_idx_d = frame_idx_q + 9'd1;
              end
            end else begin
              vs_cnt_d = vs_cnt_q + CntW'(1);
            end
          end
        end
        StHold: if (vs_fall && rdy_q) state_d = StRun;
        default: state_d = StIdle;
      endcase
    end
  end

  // A vsync edge arriving while the pulse is live is ignored rather than extending it.
  always_comb begin
    trig_cnt_d = trig_cnt_q;
    if (trig_cnt_q != '0)  trig_cnt_d = trig_cnt_q - TrigW'(1);
    else if (trig_fire)    trig_cnt_d = TrigLoad;
  end

  always_ff @(posedge clk_25 or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      vs_cnt_q    <= '0;
      frame_idx_q <= '0;
      seq_done_q  <= 1'b0;
      trig_cnt_q  <= '0;
      cam_trig_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      vs_cnt_q    <= vs_cnt_d;
      frame_idx_q <= frame_idx_d;
      seq_done_q  <= seq_done_d;
      trig_cnt_q  <= trig_cnt_d;
      cam_trig_q  <= (trig_cnt_d != '0);
    end
  end

  // Dropping into IDLE reloads the index-0 words even when frame_idx was already 0.
  assign div_start = (frame_idx_d != frame_idx_q) || ((state_d == StIdle) && (state_q != StIdle));

  always_comb begin
    k_val   = 32'd1;
    off_val = '0;
    dc_val  = 1'b0;
    if (frame_idx_d < 9'(NumPhase)) begin
      k_val   = 32'(frame_idx_d >> STEP_LOG2) + 32'd1;
      off_val = 32'(frame_idx_d & 9'(NumStep - 1)) << (32 - STEP_LOG2);
    end else begin
      dc_val  = 1'b1;
      off_val = 32'(frame_idx_d - 9'(NumPhase)) << (32 - STEP_LOG2);
    end
  end

  assign rem_sh   = {div_rem_q, div_quo_q[31]};
  assign rem_diff = rem_sh - {1'b0, div_den_q};

  // 32 restoring iterations run at counts 0..31; the words land when the count reaches 33,
  // giving a fixed 34-cycle latency from the index change.
  always_ff @(posedge clk_25 or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt_q   <= '0;
      div_rem_q   <= '0;
      div_quo_q   <= '0;
      div_den_q   <= 32'd1;
      div_dc_q    <= 1'b0;
      off_pend_q  <= '0;
      busy_q      <= 1'b0;
      phase_inc_q <= Dividend;
      phase_off_q <= '0;
    end else if (div_start) begin
      div_cnt_q  <= '0;
      div_rem_q  <= '0;
      div_quo_q  <= Dividend;
      div_den_q  <= k_val;
      div_dc_q   <= dc_val;
      off_pend_q <= off_val;
      busy_q     <= 1'b1;
    end else if (busy_q) begin
      div_cnt_q <= div_cnt_q + 6'd1;
      if (div_cnt_q < 6'd32) begin
        if (!rem_diff[32]) begin
          div_rem_q <= rem_diff[31:0];
          div_quo_q <= {div_quo_q[30:0], 1'b1};
        end else begin
          div_rem_q <= rem_sh[31:0];
          div_quo_q <= {div_quo_q[30:0], 1'b0};
        end
      end else if (div_cnt_q == 6'd33) begin
        phase_inc_q <= div_dc_q ? 32'd0 : div_quo_q;
        phase_off_q <= off_pend_q;
        busy_q      <= 1'b0;
      end
    end
  end

  assign phase_inc = phase_inc_q;
  assign phase_off = phase_off_q;
  assign frame_idx = frame_idx_q;
  assign cam_trig  = cam_trig_q;
  assign seq_done  = seq_done_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_fringe_sequencer.sv
// Directed bench for fringe_sequencer: vsync/handshake stimulus with hand-computed phase words.
module tb_fringe_sequencer;

  logic        clk_25 = 1'b0;
  logic        reset_n, sync_vs, sync_in_1, sync_in_2;
  logic [31:0] phase_inc, phase_off;
  logic [8:0]  frame_idx;
  logic        cam_trig, seq_done, busy;

  int n_cmp = 0;
  int n_err = 0;

  // Monitor state, sampled on the falling edge.
  int          cyc = 0, chg_cyc = 0, done_cyc = 0, from_idx = 0;
  int          trig_count = 0, sd_count = 0, word_err = 0;
  int          run_len = 0, max_run = 0, min_run = 1000;
  logic [8:0]  idx_prev = '0;
  logic        busy_prev = 1'b0, trig_prev = 1'b0, mon_en = 1'b0;
  logic [31:0] inc_prev = 32'h2000_0000, off_prev = '0;
  int          tc0, sd0;

  fringe_sequencer dut (
    .clk_25    (clk_25),
    .reset_n   (reset_n),
    .sync_vs   (sync_vs),
    .sync_in_1 (sync_in_1),
    .sync_in_2 (sync_in_2),
    .phase_inc (phase_inc),
    .phase_off (phase_off),
    .frame_idx (frame_idx),
    .cam_trig  (cam_trig),
    .seq_done  (seq_done),
    .busy      (busy)
  );

  always #20 clk_25 = ~clk_25;

  always @(negedge clk_25) begin
    cyc <= cyc + 1;
    if (cam_trig) begin
      run_len <= run_len + 1;
    end else if (run_len != 0) begin
      if (run_len > max_run) max_run <= run_len;
      if (run_len < min_run) min_run <= run_len;
      run_len <= 0;
    end
    if (cam_trig && !trig_prev) trig_count <= trig_count + 1;
    if (seq_done) sd_count <= sd_count + 1;
    if (frame_idx != idx_prev) begin
      from_idx <= int'(idx_prev);
      chg_cyc  <= cyc;
    end
    if (busy_prev && !busy) done_cyc <= cyc;
    if (mon_en && ((phase_inc != inc_prev) || (phase_off != off_prev)) && !(busy_prev && !busy))
      word_err <= word_err + 1;
    idx_prev  <= frame_idx;
    busy_prev <= busy;
    trig_prev <= cam_trig;
    inc_prev  <= phase_inc;
    off_prev  <= phase_off;
  end

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic vsync(input int hi, input int lo);
    sync_vs = 1'b1;
    repeat (hi) @(negedge clk_25);
    sync_vs = 1'b0;
    repeat (lo) @(negedge clk_25);
  endtask

  task automatic advance(input int n);
    repeat (2 * n) vsync(2, 2);
    repeat (40) @(negedge clk_25);
  endtask

  initial begin
    #(40 * 60000);
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n   = 1'b0;
    sync_vs   = 1'b0;
    sync_in_1 = 1'b0;
    sync_in_2 = 1'b1;
    repeat (3) @(negedge clk_25);
    check_value("rst_idx",  32'(frame_idx), 32'd0);
    check_value("rst_inc",  phase_inc, 32'h2000_0000);
    check_value("rst_off",  phase_off, 32'd0);
    check_value("rst_trig", 32'(cam_trig), 32'd0);
    check_value("rst_done", 32'(seq_done), 32'd0);
    check_value("rst_busy", 32'(busy), 32'd0);
    reset_n = 1'b1;
    mon_en  = 1'b1;

    // 1: disabled, vsyncs do nothing
    repeat (5) vsync(4, 10);
    check_value("t1_idx",  32'(frame_idx), 32'd0);
    check_value("t1_trig", 32'(trig_count), 32'd0);
    check_value("t1_inc",  phase_inc, 32'h2000_0000);

    // 2: enable, one arming vsync, then triggers on vsyncs 1 and 3 only
    sync_in_1 = 1'b1;
    repeat (4) @(negedge clk_25);
    vsync(4, 10);
    check_value("t2_arm_trig", 32'(trig_count), 32'd0);
    vsync(4, 40);
    check_value("t2_v1_trig", 32'(trig_count), 32'd1);
    vsync(4, 40);
    check_value("t2_v2_trig", 32'(trig_count), 32'd1);
    check_value("t2_v2_idx",  32'(frame_idx), 32'd1);
    check_value("t2_lat",     32'(done_cyc - chg_cyc), 32'd34);
    check_value("t2_inc",     phase_inc, 32'h2000_0000);
    check_value("t2_off",     phase_off, 32'h2000_0000);
    check_value("t2_busy",    32'(busy), 32'd0);
    vsync(4, 40);
    check_value("t2_v3_trig", 32'(trig_count), 32'd2);
    vsync(4, 40);
    check_value("t2_v4_trig", 32'(trig_count), 32'd2);
    check_value("t2_v4_idx",  32'(frame_idx), 32'd2);

    // 3: K=2 at idx 8
    advance(6);
    check_value("t3_idx8", 32'(frame_idx), 32'd8);
    check_value("t3_inc8", phase_inc, 32'h1000_0000);
    check_value("t3_off8", phase_off, 32'd0);
    check_value("t3_lat8", 32'(done_cyc - chg_cyc), 32'd34);

    // 5: camera not ready at idx 10
    advance(2);
    check_value("t5_idx", 32'(frame_idx), 32'd10);
    sync_in_2 = 1'b0;
    repeat (3) @(negedge clk_25);
    tc0 = trig_count;
    repeat (3) vsync(4, 40);
    check_value("t5_hold_idx",  32'(frame_idx), 32'd10);
    check_value("t5_hold_trig", 32'(trig_count - tc0), 32'd0);
    sync_in_2 = 1'b1;
    repeat (3) @(negedge clk_25);
    vsync(4, 40);
    check_value("t5_resume_idx",  32'(frame_idx), 32'd10);
    check_value("t5_resume_trig", 32'(trig_count - tc0), 32'd0);
    vsync(4, 40);
    check_value("t5_v1_trig", 32'(trig_count - tc0), 32'd1);
    check_value("t5_v1_idx",  32'(frame_idx), 32'd10);
    vsync(4, 40);
    check_value("t5_v2_idx",  32'(frame_idx), 32'd11);

    // 3 (cont): K=3, step 3 at idx 19
    advance(8);
    check_value("t3_idx19", 32'(frame_idx), 32'd19);
    check_value("t3_inc19", phase_inc, 32'd178956970);
    check_value("t3_off19", phase_off, 32'h6000_0000);

    // 6: idx 200 (K=26), then ena drop coincident with an advancing vs_fall
    advance(181);
    check_value("t6_idx200", 32'(frame_idx), 32'd200);
    check_value("t6_inc200", phase_inc, 32'd20648881);
    check_value("t6_off200", phase_off, 32'd0);
    vsync(2, 2);
    sd0 = sd_count;
    sync_vs = 1'b1;
    repeat (3) @(negedge clk_25);
    sync_in_1 = 1'b0;
    repeat (2) @(negedge clk_25);
    sync_vs = 1'b0;
    repeat (40) @(negedge clk_25);
    check_value("t6_idx",  32'(frame_idx), 32'd0);
    check_value("t6_from", 32'(from_idx), 32'd200);
    check_value("t6_lat",  32'(done_cyc - chg_cyc), 32'd34);
    check_value("t6_inc",  phase_inc, 32'h2000_0000);
    check_value("t6_off",  phase_off, 32'd0);
    check_value("t6_done", 32'(sd_count - sd0), 32'd0);
    repeat (2) vsync(4, 10);
    check_value("t6_idle_idx", 32'(frame_idx), 32'd0);

    // 4: DC frames and wrap
    sync_in_1 = 1'b1;
    repeat (4) @(negedge clk_25);
    vsync(2, 2);
    advance(480);
    check_value("t4_idx480", 32'(frame_idx), 32'd480);
    check_value("t4_inc480", phase_inc, 32'd0);
    check_value("t4_off480", phase_off, 32'd0);
    check_value("t4_lat480", 32'(done_cyc - chg_cyc), 32'd34);
    advance(7);
    check_value("t4_idx487", 32'(frame_idx), 32'd487);
    check_value("t4_inc487", phase_inc, 32'd0);
    check_value("t4_off487", phase_off, 32'hE000_0000);
    sd0 = sd_count;
    advance(1);
    check_value("t4_wrap_idx",  32'(frame_idx), 32'd0);
    check_value("t4_wrap_from", 32'(from_idx), 32'd487);
    check_value("t4_wrap_done", 32'(sd_count - sd0), 32'd1);
    check_value("t4_wrap_inc",  phase_inc, 32'h2000_0000);
    check_value("t4_wrap_off",  phase_off, 32'd0);

    check_value("trig_max_len", 32'(max_run), 32'd16);
    check_value("trig_min_len", 32'(min_run), 32'd16);
    check_value("word_stable",  32'(word_err), 32'd0);

    // 6 (cont): reset in the middle of the idx 1 -> 2 divide
    advance(1);
    check_value("t6r_off1", phase_off, 32'h2000_0000);
    vsync(2, 2);
    sync_vs = 1'b1;
    repeat (2) @(negedge clk_25);
    sync_vs = 1'b0;
    repeat (10) @(negedge clk_25);
    check_value("t6r_busy_pre", 32'(busy), 32'd1);
    check_value("t6r_idx_pre",  32'(frame_idx), 32'd2);
    mon_en  = 1'b0;
    reset_n = 1'b0;
    #1;
    check_value("t6r_idx",  32'(frame_idx), 32'd0);
    check_value("t6r_inc",  phase_inc, 32'h2000_0000);
    check_value("t6r_off",  phase_off, 32'd0);
    check_value("t6r_busy", 32'(busy), 32'd0);
    check_value("t6r_trig", 32'(cam_trig), 32'd0);
    check_value("t6r_done", 32'(seq_done), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
